fixed_to_fp_seq: RTL and testbench

- Iterative, handshaked converter from signed fixed-point CORDIC results to IEEE-754 single precision.
- It is the fixed→float end of the datapath, returning results to the float domain.
- Replaces the combinational converter where the result path needs valid/ready flow control and a short critical path.
- Normalisation is done by a shift-and-count FSM, one bit per cycle.

---
 rtl/fixed_to_fp_seq.sv | 88 ++++++++
 tb/tb_fixed_to_fp_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_fp_seq.sv
// fixed_to_fp_seq: iterative signed fixed-point to IEEE-754 single converter with valid/ready handshake.
// Define FX2FP_ONECYCLE_NORM_EN to normalise in one cycle through a leading-zero priority encoder.
module fixed_to_fp_seq #(
    parameter int WORD_LENGTH = 21,
    parameter int FRAC_BITS   = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out,
    output logic                   busy
);
    localparam int W = WORD_LENGTH;
    localparam logic [8:0] EXP0 = 9'(127 + W - 1 - FRAC_BITS);
    typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;
    state_t state, state_nxt;
    logic [W-1:0] mag, mag_nxt, abs_in;
    logic [8:0] expo, expo_nxt;
    logic sign, sign_nxt;
    logic [31:0] out_nxt;
    logic [22:0] frac;
    assign abs_in    = in[W-1] ? -in : in;
    assign frac      = 23'(mag[W-2:0]) << (24 - W);
    assign in_ready  = state == IDLE;
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;
`ifdef FX2FP_ONECYCLE_NORM_EN
    logic [4:0] lz;
    always_comb begin
        lz = '0;
        for (int i = 0; i < W; i++) if (mag[i]) lz = 5'(W - 1 - i);
    end
`endif
    always_comb begin
        state_nxt = state;
        mag_nxt   = mag;
        expo_nxt  = expo;
        sign_nxt  = sign;
        out_nxt   = out;
        case (state)
            IDLE: if (in_valid) begin
                sign_nxt  = in[W-1];
                mag_nxt   = abs_in;
                expo_nxt  = EXP0;
                state_nxt = (abs_in == '0) ? PACK : NORM;
            end
            NORM: begin
`ifdef FX2FP_ONECYCLE_NORM_EN
                mag_nxt   = mag << lz;
                expo_nxt  = expo - 9'(lz);
                state_nxt = PACK;
`else
                if (mag[W-1]) state_nxt = PACK;
                else begin
                    mag_nxt  = mag << 1;
                    expo_nxt = expo - 9'd1;
                end
`endif
            end
            // zero keeps the initial exponent, so it is forced to +0.0 here
            PACK: begin
                out_nxt   = (mag == '0) ? 32'h0 : {sign, expo[7:0], frac};
                state_nxt = HOLD;
            end
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mag   <= '0;
            expo  <= '0;
            sign  <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            mag   <= mag_nxt;
            expo  <= expo_nxt;
            sign  <= sign_nxt;
            out   <= out_nxt;
        end
    end
endmodule

// File: tb/tb_fixed_to_fp_seq.sv
// tb_fixed_to_fp_seq: directed and random scoreboard bench for fixed_to_fp_seq.
module tb_fixed_to_fp_seq;
    localparam int W = 21;
    localparam int F = 19;
`ifdef FX2FP_ONECYCLE_NORM_EN
    localparam bit ONE = 1'b1;
`else
    localparam bit ONE = 1'b0;
`endif
    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [W-1:0] din = '0;
    logic in_ready, out_valid, busy;
    logic [31:0] dout, held;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen = 1'b0;
    bit done = 1'b0;
    fixed_to_fp_seq #(.WORD_LENGTH(W), .FRAC_BITS(F)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din),
        .out_valid(out_valid), .out_ready(out_ready), .out(dout), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int lat_of(input int l, input bit zero);
        return zero ? 1 : (ONE ? 2 : l + 2);
    endfunction
    // reference: locate the top set bit and place the mantissa directly
    function automatic logic [31:0] ref_fp(input logic [W-1:0] v, output int lat);
        int sv, m, p, e;
        logic [31:0] fr;
        sv = int'($signed(v));
        m = sv < 0 ? -sv : sv;
        lat = 1;
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < W; i++) if (m[i]) p = i;
        e = 127 + p - F;
        fr = 32'(m) << (23 - p);
        lat = lat_of(W - 1 - p, 1'b0);
        return {v[W-1], e[7:0], fr[22:0]};
    endfunction
    task automatic send(input logic [W-1:0] v, input logic [31:0] e, input int l);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        din = v;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                q.push_back('{val: e, lat: l, acc: cyc + 1});
            end
        end
        checks++;
        assert (ok) else begin errors++; $error("FAIL accept_timeout: in=%h accepted=%b want 1", v, ok); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din = W'($urandom);
    endtask
    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = q.size() == 0 && in_ready;
        end
        checks++;
        assert (ok) else begin errors++; $error("FAIL drain_timeout: pending=%0d want 0", q.size()); end
    endtask
    always @(negedge clk) begin
        if (!rst) seen = 1'b0;
        else begin
            checks++;
            assert (busy === !in_ready) else begin errors++; $error("FAIL busy: got %b want %b", busy, !in_ready); end
            if (out_valid) begin
                checks++;
                assert (q.size() != 0) else begin errors++; $error("FAIL spurious: out=%h pending=%0d want >0", dout, q.size()); end
                if (q.size() != 0) begin
                    if (!seen) begin
                        seen = 1'b1;
                        held = dout;
                        checks++;
                        assert (cyc - q[0].acc === q[0].lat) else begin errors++; $error("FAIL latency: got %0d want %0d", cyc - q[0].acc, q[0].lat); end
                    end else begin
                        checks++;
                        assert (dout === held) else begin errors++; $error("FAIL hold_stable: got %h want %h", dout, held); end
                    end
                    if (out_ready) begin
                        checks++;
                        assert (dout === q[0].val) else begin errors++; $error("FAIL result: got %h want %h", dout, q[0].val); end
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end
    initial begin
        logic [W-1:0] v;
        logic [31:0] e;
        int l;
        #1 rst = 1'b0;
        #1;
        checks += 4;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready: got %b want 1", in_ready); end
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid: got %b want 0", out_valid); end
        assert (dout === 32'h0) else begin errors++; $error("FAIL rst_out: got %h want 0", dout); end
        assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        send(21'h080000, 32'h3F800000, lat_of(1, 1'b0));
        send(21'h040000, 32'h3F000000, lat_of(2, 1'b0));
        send(21'h0C0000, 32'h3FC00000, lat_of(1, 1'b0));
        send(21'h100000, 32'hC0000000, lat_of(0, 1'b0));
        send(21'h1FFFFF, 32'hB6000000, lat_of(20, 1'b0));
        send(21'h000000, 32'h00000000, lat_of(0, 1'b1));
        drain();
        out_ready = 1'b0;
        send(21'h080000, 32'h3F800000, lat_of(1, 1'b0));
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            din = W'($urandom);
            @(negedge clk);
            checks += 3;
            assert (dout === 32'h3F800000) else begin errors++; $error("FAIL stall_out: got %h want 3f800000", dout); end
            assert (out_valid === 1'b1) else begin errors++; $error("FAIL stall_valid: got %b want 1", out_valid); end
            assert (in_ready === 1'b0) else begin errors++; $error("FAIL stall_in_ready: got %b want 0", in_ready); end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL post_hs_in_ready: got %b want 1", in_ready); end
        send(21'h1FFFFF, 32'hB6000000, lat_of(20, 1'b0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        q.delete();
        checks += 4;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL abort_in_ready: got %b want 1", in_ready); end
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL abort_out_valid: got %b want 0", out_valid); end
        assert (dout === 32'h0) else begin errors++; $error("FAIL abort_out: got %h want 0", dout); end
        assert (busy === 1'b0) else begin errors++; $error("FAIL abort_busy: got %b want 0", busy); end
        #1 rst = 1'b1;
        send(21'h080000, 32'h3F800000, lat_of(1, 1'b0));
        drain();
        fork
            begin
                for (int i = 0; i < 2500; i++) begin
                    v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
                    if ($urandom_range(0, 7) == 0) v = -v;
                    e = ref_fp(v, l);
                    send(v, e, l);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1 out_ready = $urandom_range(0, 3) != 0;
            end
        join
        out_ready = 1'b1;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
